muldiv_issue: RTL and testbench

- Pipeline-side front end for the M-extension multiply/divide unit, sitting directly upstream of it.
- Accepts one decoded M-ext instruction (funct3, rs1/rs2 values, rd) from the execute stage and drives the unit's start/operand/op-select inputs.
- Holds operands stable until the unit signals done, stalls the core meanwhile, and presents the result to writeback with a valid/ready handshake.
- Also handles flush while the unit is busy and a watchdog timeout.

---
 rtl/muldiv_issue.sv | 181 ++++++++++++++++++
 tb/tb_muldiv_issue.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_issue.sv
// Issue/hold front end for the M-extension multiply/divide unit: latches one instruction,
// pulses start, waits for done (or watchdog), then hands the result to writeback.
// Optional result cache for repeated operations: `define MULDIV_RESULT_CACHE_EN.
module muldiv_issue #(
    parameter int WATCHDOG_CYCLES = 80,
    parameter int CNT_W           = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic [4:0]  rd_i,
    input  logic        flush_i,
    input  logic        wb_ready_i,
    output logic        busy_o,
    output logic        result_valid_o,
    output logic [31:0] result_o,
    output logic [4:0]  rd_o,
    output logic        err_o,
    output logic        md_start_o,
    output logic [31:0] md_in_A_o,
    output logic [31:0] md_in_B_o,
    output logic [1:0]  md_op_mul_o,
    output logic [1:0]  md_op_div_o,
    output logic        md_sel_o,
    input  logic [31:0] md_R_i,
    input  logic        md_done_i
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [31:0]        r_res;
    logic [2:0]         r_f3;
    logic [4:0]         r_rd;
    logic [CNT_W-1:0]   r_wd;
    logic               w_accept;
    logic               w_hit;
    logic               w_expire;
    logic               w_capture;
    logic               w_waiting;
    logic [31:0]        w_hit_res;

    assign w_waiting = (r_state == S_WAIT) || (r_state == S_DRAIN);
    assign w_accept  = (r_state == S_IDLE) && valid_i && !flush_i;
    // Expiry is decided from registered state only, so it wins over a done arriving in the same cycle.
    assign w_expire  = w_waiting && (r_wd == CNT_W'(WATCHDOG_CYCLES - 1));
    assign w_capture = (r_state == S_WAIT) && md_done_i && !flush_i && !w_expire;

`ifdef MULDIV_RESULT_CACHE_EN
    logic               r_c_vld;
    logic [2:0]         r_c_f3;
    logic [31:0]        r_c_a;
    logic [31:0]        r_c_b;
    logic [31:0]        r_c_res;

    assign w_hit     = r_c_vld && (r_c_f3 == funct3_i) && (r_c_a == rs1_i) && (r_c_b == rs2_i);
    assign w_hit_res = r_c_res;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_c_vld <= 1'b0;
            r_c_f3  <= '0;
            r_c_a   <= '0;
            r_c_b   <= '0;
            r_c_res <= '0;
        end else if (w_capture) begin
            r_c_vld <= 1'b1;
            r_c_f3  <= r_f3;
            r_c_a   <= r_a;
            r_c_b   <= r_b;
            r_c_res <= md_R_i;
        end else if (w_expire || ((r_state == S_DRAIN) && md_done_i)) begin
            r_c_vld <= 1'b0;
        end
    end
`else
    assign w_hit     = 1'b0;
    assign w_hit_res = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        busy_o         = 1'b1;
        result_valid_o = 1'b0;
        md_start_o     = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy_o = valid_i;
                if (w_accept) begin
                    w_next = w_hit ? S_HOLD : S_ISSUE;
                end
            end
            S_ISSUE: begin
                md_start_o = 1'b1;
                w_next     = flush_i ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (w_expire || md_done_i) begin
                    w_next = flush_i ? S_IDLE : S_HOLD;
                end else if (flush_i) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_expire || md_done_i) begin
                    w_next = S_IDLE;
                end
            end
            S_HOLD: begin
                result_valid_o = 1'b1;
                if (wb_ready_i) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_f3  <= '0;
            r_rd  <= '0;
            r_res <= '0;
            r_wd  <= '0;
        end else begin
            // A cache hit leaves the unit-facing operands untouched; only rd and the result move.
            if (w_accept) begin
                r_rd <= rd_i;
                if (w_hit) begin
                    r_res <= w_hit_res;
                end else begin
                    r_a  <= rs1_i;
                    r_b  <= rs2_i;
                    r_f3 <= funct3_i;
                end
            end
            if (r_state == S_ISSUE) begin
                r_wd <= '0;
            end else if (w_waiting && !w_expire) begin
                r_wd <= r_wd + CNT_W'(1);
            end
            if (w_capture) begin
                r_res <= md_R_i;
            end else if (w_expire && (r_state == S_WAIT)) begin
                r_res <= '0;
            end
        end
    end

    assign err_o       = w_expire;
    assign result_o    = r_res;
    assign rd_o        = r_rd;
    assign md_in_A_o   = r_a;
    assign md_in_B_o   = r_b;
    assign md_op_mul_o = r_f3[1:0];
    assign md_op_div_o = r_f3[1:0];
    assign md_sel_o    = r_f3[2];

endmodule

// File: tb/tb_muldiv_issue.sv
// Scoreboard bench for muldiv_issue: behavioural M-ext unit with programmable latency,
// golden arithmetic model, directed corner cases plus a randomized instruction stream.
module tb_muldiv_issue;

    localparam int WD = 80;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_i = 1'b0;
    logic [2:0]  funct3_i = '0;
    logic [31:0] rs1_i = '0;
    logic [31:0] rs2_i = '0;
    logic [4:0]  rd_i = '0;
    logic        flush_i = 1'b0;
    logic        wb_ready_i = 1'b1;
    logic        busy_o;
    logic        result_valid_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;
    logic        err_o;
    logic        md_start_o;
    logic [31:0] md_in_A_o;
    logic [31:0] md_in_B_o;
    logic [1:0]  md_op_mul_o;
    logic [1:0]  md_op_div_o;
    logic        md_sel_o;
    logic [31:0] md_R_i = '0;
    logic        md_done_i = 1'b0;

    muldiv_issue #(.WATCHDOG_CYCLES(WD), .CNT_W(7)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .funct3_i(funct3_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .flush_i(flush_i),
        .wb_ready_i(wb_ready_i), .busy_o(busy_o), .result_valid_o(result_valid_o),
        .result_o(result_o), .rd_o(rd_o), .err_o(err_o), .md_start_o(md_start_o),
        .md_in_A_o(md_in_A_o), .md_in_B_o(md_in_B_o), .md_op_mul_o(md_op_mul_o),
        .md_op_div_o(md_op_div_o), .md_sel_o(md_sel_o), .md_R_i(md_R_i),
        .md_done_i(md_done_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // RISC-V M-extension semantics, including divide-by-zero and signed overflow.
    function automatic logic [31:0] golden(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (f3 == 3'b001 || f3 == 3'b010) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (f3 == 3'b001) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        case (f3)
            3'b000: return p[31:0];
            3'b001, 3'b010, 3'b011: return p[63:32];
            3'b100: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                return $signed(a) / $signed(b);
            end
            3'b101: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Behavioural unit: done arrives unit_L-1 cycles after start; unit_L=0 never completes.
    int unit_L = 3;
    int unit_cnt = 0;
    always @(negedge clk) begin
        md_done_i = 1'b0;
        md_R_i = $urandom();
        if (unit_cnt > 0) begin
            unit_cnt--;
            if (unit_cnt == 0) begin
                md_done_i = 1'b1;
                md_R_i = golden({md_sel_o, md_sel_o ? md_op_div_o : md_op_mul_o}, md_in_A_o, md_in_B_o);
            end
        end
        if (md_start_o && unit_L > 0) unit_cnt = unit_L - 1;
    end

    int rdy_mode = 1;
    always @(negedge clk) begin
        case (rdy_mode)
            0: wb_ready_i = 1'b0;
            1: wb_ready_i = 1'b1;
            default: wb_ready_i = 1'($urandom_range(0, 1));
        endcase
    end

    logic [36:0] q[$];
    int n_start = 0, start_cyc = 0, n_err = 0, err_cyc = 0;

    always @(negedge clk) begin
        #1;
        if (md_start_o) begin n_start++; start_cyc = cyc; end
        if (err_o) begin n_err++; err_cyc = cyc; end
        if (result_valid_o) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=%0h rd=%0d required=no result", result_o, rd_o);
            end else begin
                chk("result", result_o, q[0][31:0]);
                chk("rd", rd_o, q[0][36:32]);
                if (wb_ready_i) void'(q.pop_front());
            end
        end
    end

    int t0 = 0;

    task automatic wait_for(input int which, input int bound, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < bound && !hit; i++) begin
            @(negedge clk); #2;
            case (which)
                0: hit = result_valid_o;
                1: hit = md_done_i;
                2: hit = err_o;
                default: hit = !busy_o;
            endcase
        end
        chk(name, hit, 1);
    endtask

    task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit expect_res);
        wait_for(3, 300, "timeout_idle");
        @(negedge clk);
        valid_i = 1'b1; funct3_i = f3; rs1_i = a; rs2_i = b; rd_i = rd;
        t0 = cyc;
        if (expect_res) q.push_back({rd, golden(f3, a, b)});
        #2 chk("busy_same_cycle", busy_o, 1);
        @(negedge clk);
        valid_i = 1'b0;
        #2;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench time limit");
    end

    initial begin
        int ns, ne;
        repeat (3) @(negedge clk);
        #2;
        chk("reset_ctrl", {busy_o, result_valid_o, err_o, md_start_o, rd_o, md_op_mul_o, md_op_div_o, md_sel_o}, 0);
        chk("reset_data", {result_o, md_in_A_o}, 0);
        chk("reset_B", md_in_B_o, 0);
        @(negedge clk); reset = 1'b0;

        // MUL 7 * -3, held at writeback for 5 cycles
        unit_L = 3; rdy_mode = 0; ns = n_start;
        send(3'b000, 32'd7, 32'hFFFFFFFD, 5'd3, 1);
        chk("t1_start", md_start_o, 1);
        chk("t1_op", {md_sel_o, md_op_mul_o}, 3'b000);
        wait_for(0, 20, "timeout_t1_rv");
        chk("t1_latency", cyc - t0, 4);
        chk("t1_nstart", n_start - ns, 1);
        repeat (5) begin @(negedge clk); #2; chk("t1_hold", result_valid_o, 1); end
        rdy_mode = 1;

        // DIVU by zero; operands must stay put until done
        unit_L = 5;
        send(3'b101, 32'd100, 32'd0, 5'd5, 1);
        chk("t2_op", {md_sel_o, md_op_div_o}, 3'b101);
        wait_for(1, 20, "timeout_t2_done");
        chk("t2_opnd_at_done", {md_in_A_o, md_in_B_o}, {32'd100, 32'd0});
        wait_for(0, 5, "timeout_t2_rv");
        chk("t2_latency", cyc - t0, 6);

        // REM flushed in WAIT: drains silently
        unit_L = 10;
        send(3'b110, 32'd17, 32'd5, 5'd7, 0);
        @(negedge clk); flush_i = 1'b1;
        @(negedge clk); flush_i = 1'b0;
        wait_for(1, 20, "timeout_t3_done");
        chk("t3_busy_at_done", busy_o, 1);
        @(negedge clk); #2;
        chk("t3_busy_after_done", busy_o, 0);
        unit_L = 4;
        send(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 1);

        // valid with flush in IDLE is dropped
        wait_for(3, 300, "timeout_idle");
        ns = n_start;
        @(negedge clk); valid_i = 1'b1; flush_i = 1'b1; funct3_i = 3'b000; rs1_i = 32'd9; rs2_i = 32'd9;
        #2 chk("idle_flush_busy", busy_o, 1);
        @(negedge clk); valid_i = 1'b0; flush_i = 1'b0;
        #2 chk("idle_flush_busy_next", busy_o, 0);
        @(negedge clk); #2;
        chk("idle_flush_nostart", n_start - ns, 0);

        // watchdog: unit never answers
        unit_L = 0; rdy_mode = 0; ne = n_err;
        send(3'b001, 32'h1234, 32'h5678, 5'd9, 0);
        q.push_back({5'd9, 32'd0});
        wait_for(2, 150, "timeout_t4_err");
        chk("t4_wd_latency", err_cyc - start_cyc, WD);
        @(negedge clk); #2;
        chk("t4_err_pulse", err_o, 0);
        chk("t4_valid", result_valid_o, 1);
        rdy_mode = 1;
        wait_for(3, 20, "timeout_t4_idle");
        chk("t4_nerr", n_err - ne, 1);

        // reset in WAIT, late done must be ignored
        unit_L = 8;
        send(3'b100, 32'd1000, 32'd7, 5'd4, 0);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        #2;
        chk("t5_reset_ctrl", {busy_o, result_valid_o, err_o, md_start_o, rd_o, md_op_mul_o, md_op_div_o, md_sel_o}, 0);
        chk("t5_reset_data", {result_o, md_in_A_o}, 0);
        wait_for(1, 20, "timeout_t5_done");
        chk("t5_busy_at_done", {busy_o, result_valid_o}, 0);
        @(negedge clk); #2;
        chk("t5_after_done", {busy_o, result_valid_o, md_start_o}, 0);
        unit_L = 3;
        send(3'b100, 32'd1000, 32'd7, 5'd4, 1);

`ifdef MULDIV_RESULT_CACHE_EN
        unit_L = 4;
        send(3'b100, 32'd20, 32'd3, 5'd11, 1);
        wait_for(3, 300, "timeout_idle");
        ns = n_start;
        send(3'b100, 32'd20, 32'd3, 5'd12, 1);
        chk("cache_hit_valid", result_valid_o, 1);
        chk("cache_hit_opnd", {md_in_A_o, md_in_B_o}, {32'd20, 32'd3});
        chk("cache_hit_nostart", n_start - ns, 0);
        send(3'b110, 32'd20, 32'd3, 5'd13, 1);
        chk("cache_miss_start", md_start_o, 1);
        wait_for(3, 300, "timeout_idle");
        chk("cache_miss_nstart", n_start - ns, 1);
`endif

        // randomized instruction stream with random writeback back-pressure
        rdy_mode = 2;
        for (int i = 0; i < 24; i++) begin
            unit_L = $urandom_range(2, 6);
            send(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom_range(0, 31)), 1);
        end
        rdy_mode = 1;
        wait_for(3, 300, "timeout_final_idle");
        chk("queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
